// File: rtl/score_pkg.sv
// Shared constants for the BCD score accumulator: FSM encoding, default point
// table, saturation value and BCD digit width.
package score_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [15:0] PTS_1_DEF     = 16'h0010;
  localparam logic [15:0] PTS_2_DEF     = 16'h0030;
  localparam logic [15:0] PTS_3_DEF     = 16'h0050;
  localparam logic [15:0] PTS_4_DEF     = 16'h0080;
  localparam logic [15:0] SAT_VALUE_DEF = 16'h9999;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: digit + digit + carry_in -> decimal digit, carry_out.
// Operands are assumed to be valid BCD (0..9).
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_sum,
  output logic               o_cout
);

  logic [DIGIT_W:0] w_raw;

  assign w_raw = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};

  // Decimal correction of the binary digit sum
  always_comb begin
    o_sum  = w_raw[DIGIT_W-1:0];
    o_cout = 1'b0;
    if (w_raw > 5'd9) begin
      o_sum  = w_raw[DIGIT_W-1:0] - 4'd10;
      o_cout = 1'b1;
    end else begin
      o_sum  = w_raw[DIGIT_W-1:0];
      o_cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_bcd_accum.sv
// Line-clear score accumulator: digit-serial BCD add into a shadow accumulator,
// atomic commit to score_out, 1-deep pending event slot and session high score.
module score_bcd_accum
  import score_pkg::*;
#(
  parameter logic [15:0] PTS_1     = PTS_1_DEF,
  parameter logic [15:0] PTS_2     = PTS_2_DEF,
  parameter logic [15:0] PTS_3     = PTS_3_DEF,
  parameter logic [15:0] PTS_4     = PTS_4_DEF,
  parameter logic [15:0] SAT_VALUE = SAT_VALUE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        clear_valid,
  input  logic [2:0]  lines_cleared,
  output logic [15:0] score_out,
  output logic [15:0] hi_score_out,
  output logic        busy,
  output logic        saturated,
  output logic        overflow_err
);

  state_t              r_state;
  logic [1:0]          r_digit;
  logic                r_carry;
  logic [15:0]         r_acc;
  logic [15:0]         r_addend;
  logic [15:0]         r_score;
  logic [15:0]         r_hi;
  logic                r_pend_full;
  logic [2:0]          r_pend_lines;
  logic                r_sat;
  logic                r_ovf;
  logic                r_go_def;

  logic                w_legal;
  logic                w_busy;
  logic [3:0]          w_idx;
  logic [DIGIT_W-1:0]  w_sum;
  logic                w_cout;

  function automatic logic [15:0] f_pts(input logic [2:0] lines);
    case (lines)
      3'd1:    f_pts = PTS_1;
      3'd2:    f_pts = PTS_2;
      3'd3:    f_pts = PTS_3;
      3'd4:    f_pts = PTS_4;
      default: f_pts = 16'h0000;
    endcase
  endfunction

  assign w_legal = clear_valid && (lines_cleared >= 3'd1) && (lines_cleared <= 3'd4);
  assign w_busy  = (r_state != ST_IDLE) || r_pend_full;
  assign w_idx   = {r_digit, 2'b00};

  // One shared digit adder, steered by the current digit index
  bcd_digit_add u_digit_add (
    .i_a    (r_acc[w_idx +: DIGIT_W]),
    .i_b    (r_addend[w_idx +: DIGIT_W]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // FSM, accumulator, pending slot, high score and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_digit      <= 2'd0;
      r_carry      <= 1'b0;
      r_acc        <= 16'h0000;
      r_addend     <= 16'h0000;
      r_score      <= 16'h0000;
      r_hi         <= 16'h0000;
      r_pend_full  <= 1'b0;
      r_pend_lines <= 3'd0;
      r_sat        <= 1'b0;
      r_ovf        <= 1'b0;
      r_go_def     <= 1'b0;
    end else if (game_start) begin
      // New game aborts any add in flight; the high score survives
      r_state      <= ST_IDLE;
      r_digit      <= 2'd0;
      r_carry      <= 1'b0;
      r_acc        <= 16'h0000;
      r_addend     <= 16'h0000;
      r_score      <= 16'h0000;
      r_pend_full  <= 1'b0;
      r_pend_lines <= 3'd0;
      r_sat        <= 1'b0;
      r_ovf        <= 1'b0;
      r_go_def     <= 1'b0;
    end else begin
      // A deferred game_over resolves in the idle cycle after COMMIT
      if (r_go_def && (r_state == ST_IDLE)) begin
        if (r_score > r_hi) r_hi <= r_score;
        r_go_def <= 1'b0;
      end else if (game_over) begin
        if (!w_busy) begin
          if (r_score > r_hi) r_hi <= r_score;
        end else begin
          r_go_def <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_digit <= 2'd0;
          r_carry <= 1'b0;
          if (r_pend_full) begin
            r_addend <= f_pts(r_pend_lines);
            r_acc    <= r_score;
            r_state  <= ST_ADD;
            // The slot frees as it is consumed, so a same-cycle event refills it
            if (w_legal) r_pend_lines <= lines_cleared;
            else         r_pend_full  <= 1'b0;
          end else if (w_legal) begin
            r_addend <= f_pts(lines_cleared);
            r_acc    <= r_score;
            r_state  <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_acc[w_idx +: DIGIT_W] <= w_sum;
          r_carry <= w_cout;
          r_digit <= r_digit + 2'd1;
          if (r_digit == 2'd3) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (r_carry) begin
            r_score <= SAT_VALUE;
            r_sat   <= 1'b1;
          end else begin
            r_score <= r_acc;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_legal && (r_state != ST_IDLE)) begin
        if (!r_pend_full) begin
          r_pend_full  <= 1'b1;
          r_pend_lines <= lines_cleared;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign score_out    = r_score;
  assign hi_score_out = r_hi;
  assign busy         = w_busy;
  assign saturated    = r_sat;
  assign overflow_err = r_ovf;

endmodule
